// File: rtl/aes_cozucu.sv
// Iterative AES-128 decryption core: forward key expansion to K10 (or a cached K10),
// then ten inverse rounds with round keys regenerated backwards one step per cycle.
module aes_cozucu #(
    parameter int unsigned ANAHTAR_SAKLA = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] sifre,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] blok,
    output logic         c_gecerli
);

    localparam int unsigned BLOK_W  = 128;
    localparam int unsigned SAYAC_W = 4;
    localparam logic [SAYAC_W-1:0] SON_TUR = SAYAC_W'(10);
    localparam bit SAKLA = (ANAHTAR_SAKLA != 0);

    typedef enum logic [1:0] {BOS, ANAHTAR, TUR} durum_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry x sits at bits {~x,3'b111} downto {~x,3'b000}: byte 0 is the MSB.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [SAYAC_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Row r of the state rotates right by r columns; byte index = 4*column + row.
    function automatic logic [BLOK_W-1:0] inv_shift_sub(input logic [BLOK_W-1:0] s);
        logic [BLOK_W-1:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = (((c - r + 4) % 4) * 4) + r;
                o[7'(127 - 8*(4*c + r)) -: 8] = inv_sbox(s[7'(127 - 8*src) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [BLOK_W-1:0] inv_mix(input logic [BLOK_W-1:0] s);
        logic [BLOK_W-1:0] o;
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a  = s[7'(127 - 32*c - 8*r) -: 8];
                x2 = xt(a);
                x4 = xt(x2);
                x8 = xt(x4);
                m9[r] = x8 ^ a;
                mb[r] = x8 ^ x2 ^ a;
                md[r] = x8 ^ x4 ^ a;
                me[r] = x8 ^ x4 ^ x2;
            end
            o[7'(127 - 32*c) -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end
        return o;
    endfunction

    durum_t              r_durum, w_durum;
    logic [SAYAC_W-1:0]  r_sayac, w_sayac;
    logic [BLOK_W-1:0]   r_anahtar, w_anahtar;
    logic [BLOK_W-1:0]   r_veri, w_veri;
    logic [BLOK_W-1:0]   r_blok, w_blok;
    logic                r_hazir, w_hazir;
    logic                r_c_gecerli, w_c_gecerli;
    logic [BLOK_W-1:0]   r_sakli_anahtar, w_sakli_anahtar;
    logic [BLOK_W-1:0]   r_sakli_k10, w_sakli_k10;
    logic                r_sakli_gecerli, w_sakli_gecerli;

    logic [31:0]         w_k0, w_k1, w_k2, w_k3, w_p3, w_sw, w_rc;
    logic [31:0]         w_n0, w_n1, w_n2, w_n3;
    logic [BLOK_W-1:0]   w_genislet, w_geri, w_ark, w_imc;
    logic                w_isabet;

    // One shared SubWord serves both the forward expansion and the backward step.
    assign w_k0 = r_anahtar[127:96];
    assign w_k1 = r_anahtar[95:64];
    assign w_k2 = r_anahtar[63:32];
    assign w_k3 = r_anahtar[31:0];
    assign w_p3 = w_k3 ^ w_k2;
    assign w_sw = sub_word((r_durum == TUR) ? {w_p3[23:0], w_p3[31:24]}
                                            : {w_k3[23:0], w_k3[31:24]});
    assign w_rc = {rcon(r_sayac), 24'h0};

    assign w_n0 = w_k0 ^ w_sw ^ w_rc;
    assign w_n1 = w_k1 ^ w_n0;
    assign w_n2 = w_k2 ^ w_n1;
    assign w_n3 = w_k3 ^ w_n2;
    assign w_genislet = {w_n0, w_n1, w_n2, w_n3};
    assign w_geri     = {w_k0 ^ w_sw ^ w_rc, w_k1 ^ w_k0, w_k2 ^ w_k1, w_p3};

    assign w_ark    = inv_shift_sub(r_veri) ^ r_anahtar;
    assign w_imc    = inv_mix(w_ark);
    assign w_isabet = SAKLA && r_sakli_gecerli && (anahtar == r_sakli_anahtar);

    // Next-state and next-output logic.
    always_comb begin
        w_durum         = r_durum;
        w_sayac         = r_sayac;
        w_anahtar       = r_anahtar;
        w_veri          = r_veri;
        w_blok          = r_blok;
        w_hazir         = r_hazir;
        w_c_gecerli     = 1'b0;
        w_sakli_anahtar = r_sakli_anahtar;
        w_sakli_k10     = r_sakli_k10;
        w_sakli_gecerli = r_sakli_gecerli;
        case (r_durum)
            BOS: begin
                if (g_gecerli) begin
                    w_veri  = sifre;
                    w_hazir = 1'b0;
                    if (w_isabet) begin
                        w_anahtar = r_sakli_k10;
                        w_sayac   = SON_TUR;
                        w_durum   = TUR;
                    end else begin
                        w_anahtar       = anahtar;
                        w_sakli_anahtar = anahtar;
                        w_sakli_gecerli = 1'b0;
                        w_sayac         = SAYAC_W'(1);
                        w_durum         = ANAHTAR;
                    end
                end
            end
            ANAHTAR: begin
                w_anahtar = w_genislet;
                if (r_sayac == SON_TUR) begin
                    w_sakli_k10     = w_genislet;
                    w_sakli_gecerli = SAKLA;
                    w_durum         = TUR;
                end else begin
                    w_sayac = r_sayac + SAYAC_W'(1);
                end
            end
            TUR: begin
                if (r_sayac == SON_TUR) begin
                    w_veri = r_veri ^ r_anahtar;
                end else if (r_sayac != '0) begin
                    w_veri = w_imc;
                end
                if (r_sayac == '0) begin
                    w_blok      = w_ark;
                    w_c_gecerli = 1'b1;
                    w_hazir     = 1'b1;
                    w_durum     = BOS;
                end else begin
                    w_anahtar = w_geri;
                    w_sayac   = r_sayac - SAYAC_W'(1);
                end
            end
            default: w_durum = BOS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_durum         <= BOS;
            r_sayac         <= '0;
            r_anahtar       <= '0;
            r_veri          <= '0;
            r_blok          <= '0;
            r_hazir         <= 1'b1;
            r_c_gecerli     <= 1'b0;
            r_sakli_anahtar <= '0;
            r_sakli_k10     <= '0;
            r_sakli_gecerli <= 1'b0;
        end else begin
            r_durum         <= w_durum;
            r_sayac         <= w_sayac;
            r_anahtar       <= w_anahtar;
            r_veri          <= w_veri;
            r_blok          <= w_blok;
            r_hazir         <= w_hazir;
            r_c_gecerli     <= w_c_gecerli;
            r_sakli_anahtar <= w_sakli_anahtar;
            r_sakli_k10     <= w_sakli_k10;
            r_sakli_gecerli <= w_sakli_gecerli;
        end
    end

    assign hazir     = r_hazir;
    assign blok      = r_blok;
    assign c_gecerli = r_c_gecerli;

endmodule

// File: tb/tb_aes_cozucu.sv
// Bench for aes_cozucu: a cached and an uncached instance share key/data inputs and are
// checked every cycle against a round-trip AES model (bench-side encryption).
module tb_aes_cozucu;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] anahtar, sifre;
    logic [1:0]   g;
    logic         hazir1, hazir0, c1, c0;
    logic [127:0] blok1, blok0;

    aes_cozucu #(.ANAHTAR_SAKLA(1)) dut (
        .clk(clk), .rst(rst), .anahtar(anahtar), .sifre(sifre), .g_gecerli(g[1]),
        .hazir(hazir1), .blok(blok1), .c_gecerli(c1)
    );

    aes_cozucu #(.ANAHTAR_SAKLA(0)) dut0 (
        .clk(clk), .rst(rst), .anahtar(anahtar), .sifre(sifre), .g_gecerli(g[0]),
        .hazir(hazir0), .blok(blok0), .c_gecerli(c0)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K4 = 128'h657870616e642033322d62797465206b;
    localparam logic [127:0] P4 = 128'h71776572747975696f70617364666768;

    // Expected behaviour: at most one block in flight per instance, plus last delivered block.
    bit           have_pend [2];
    int unsigned  pend_due  [2];
    logic [127:0] pend_blk  [2];
    logic [127:0] last_blk  [2];
    bit           cache_v;
    logic [127:0] cache_k;
    int unsigned  last_acc;
    bit           chk_en = 1'b0;
    int           n_vec = 0;
    int           n_err = 0;

    logic [7:0]   sb [256];
    logic [127:0] pool [3];
    logic         m_hz, m_cv;
    logic [127:0] m_bk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] y, input int n);
        logic [7:0] v;
        v = y;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    // Textbook AES-128 encryption (FIPS-197 Cipher) using the computed S-box.
    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3, rc;
        logic [31:0]  tmp;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(((i/4) + (i%4)) % 4) * 4 + (i%4)]];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit idle(input int k);
        return !have_pend[k] || (cyc >= pend_due[k]);
    endfunction

    // Present one block to the selected instances once the model says they are idle.
    task automatic send(input logic [1:0] msk, input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] ct;
        ct = aes_enc(key, pt);
        @(negedge clk);
        while ((msk[1] && !idle(1)) || (msk[0] && !idle(0))) @(negedge clk);
        anahtar = key;
        sifre   = ct;
        g       = msk;
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (msk[0]) begin
            have_pend[0] = 1'b1; pend_blk[0] = pt; pend_due[0] = cyc + 21;
        end
        if (msk[1]) begin
            have_pend[1] = 1'b1; pend_blk[1] = pt;
            pend_due[1]  = cyc + ((cache_v && cache_k == key) ? 11 : 21);
            cache_v = 1'b1;
            cache_k = key;
        end
        g       = 2'b00;
        anahtar = rnd128();
        sifre   = rnd128();
    endtask

    // Raise g_gecerli for one cycle on instances that are busy; it must be ignored.
    task automatic pulse_busy(input logic [1:0] msk);
        @(negedge clk);
        g       = {msk[1] & !idle(1), msk[0] & !idle(0)};
        anahtar = rnd128();
        sifre   = rnd128();
        @(posedge clk);
        #1;
        g = 2'b00;
    endtask

    task automatic wait_neg(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Every cycle, both instances must match the model's handshake and data.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                m_hz = (k == 1) ? hazir1 : hazir0;
                m_cv = (k == 1) ? c1 : c0;
                m_bk = (k == 1) ? blok1 : blok0;
                if (have_pend[k] && cyc == pend_due[k]) begin
                    chk($sformatf("c_gecerli pulse [%0d]", k), 128'(m_cv), 128'(1));
                    chk($sformatf("blok result [%0d]", k), m_bk, pend_blk[k]);
                    chk($sformatf("hazir at result [%0d]", k), 128'(m_hz), 128'(1));
                    last_blk[k]  = pend_blk[k];
                    have_pend[k] = 1'b0;
                end else begin
                    chk($sformatf("c_gecerli quiet [%0d]", k), 128'(m_cv), 128'(0));
                    chk($sformatf("hazir [%0d]", k), 128'(m_hz), 128'(!have_pend[k]));
                    chk($sformatf("blok held [%0d]", k), m_bk, last_blk[k]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] inv, y;
        logic [127:0] kr;
        logic [1:0] msk;
        int unsigned a;

        rst = 1'b0; g = 2'b00; anahtar = '0; sifre = '0;
        cache_v = 1'b0; cache_k = '0; last_acc = 0;
        for (int k = 0; k < 2; k++) begin
            have_pend[k] = 1'b0; pend_due[k] = 0; pend_blk[k] = '0; last_blk[k] = '0;
        end
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int z = 1; z < 256; z++) if (gmul(8'(x), 8'(z)) == 8'h01) inv = 8'(z);
            y = inv;
            sb[x] = y ^ rol(y, 1) ^ rol(y, 2) ^ rol(y, 3) ^ rol(y, 4) ^ 8'h63;
        end
        pool[0] = K1; pool[1] = K2; pool[2] = K4;

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset hazir", 128'(hazir1), 128'(1));
        chk("reset c_gecerli", 128'(c1), 128'(0));
        chk("reset blok", blok1, 128'h0);
        chk("model FIPS C.1", aes_enc(K1, P1), C1);
        chk("model FIPS B", aes_enc(K2, P2), C2);

        // T1: miss latency of 21 and a one-cycle pulse.
        send(2'b11, K1, P1);
        a = last_acc;
        wait_neg(a + 20);
        chk("T1 no pulse at 20", 128'(c1), 128'(0));
        wait_neg(a + 21);
        chk("T1 pulse at 21", 128'(c1), 128'(1));
        chk("T1 plaintext", blok1, 128'h00112233445566778899aabbccddeeff);
        chk("T1 plaintext uncached", blok0, 128'h00112233445566778899aabbccddeeff);
        wait_neg(a + 22);
        chk("T1 pulse width", 128'(c1), 128'(0));

        // T2 then T3: same key again hits the cache only on the caching instance.
        send(2'b11, K2, P2);
        send(2'b11, K2, P2);
        a = last_acc;
        wait_neg(a + 11);
        chk("T3 hit pulse at 11", 128'(c1), 128'(1));
        chk("T3 hit plaintext", blok1, 128'h3243f6a8885a308d313198a2e0370734);
        chk("T3 uncached busy at 11", 128'(c0), 128'(0));
        wait_neg(a + 21);
        chk("T3 uncached pulse at 21", 128'(c0), 128'(1));
        chk("T3 uncached plaintext", blok0, 128'h3243f6a8885a308d313198a2e0370734);

        // T4: round trip through the bench encryptor.
        send(2'b11, K4, P4);

        // T5: ignored pulses, then back-to-back blocks with different keys.
        send(2'b11, rnd128(), rnd128());
        repeat (3) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            pulse_busy(2'b11);
        end
        send(2'b10, K1, rnd128());
        send(2'b10, K4, rnd128());
        send(2'b10, K2, rnd128());

        // Randomised traffic with a small key pool so cache hits and misses mix.
        for (int n = 0; n < 24; n++) begin
            msk = 2'($urandom_range(1, 3));
            kr  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 2)] : rnd128();
            send(msk, kr, rnd128());
            if ($urandom_range(0, 3) == 0) pulse_busy(2'b11);
        end

        // T6: reset in the fifth TUR cycle of a miss, then a fresh T1 run must miss.
        send(2'b11, K2, rnd128());
        send(2'b11, K1, P1);
        a = last_acc;
        wait_neg(a + 14);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            have_pend[k] = 1'b0; last_blk[k] = '0;
        end
        cache_v = 1'b0;
        @(negedge clk);
        chk("T6 abort hazir", 128'(hazir1), 128'(1));
        chk("T6 abort blok", blok1, 128'h0);
        chk("T6 abort c_gecerli", 128'(c1), 128'(0));
        send(2'b11, K1, P1);
        a = last_acc;
        wait_neg(a + 11);
        chk("T6 cache invalidated", 128'(c1), 128'(0));
        wait_neg(a + 21);
        chk("T6 rerun pulse at 21", 128'(c1), 128'(1));
        chk("T6 rerun plaintext", blok1, 128'h00112233445566778899aabbccddeeff);

        while (!idle(0) || !idle(1)) @(negedge clk);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
